// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/grant encodings and the aborted-load value for mem_arbiter.
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, IFETCH, DACCESS, DONE} state_e;
   typedef enum logic {INSTR, DATA} grant_e;
   localparam logic [31:0] ABORT_LOAD = 32'h0;
endpackage

// File: rtl/mem_arbiter_timer.sv
// arb_timer: watchdog counter; expired_o flags the last strobe cycle before an abort.
module arb_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic nRST,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int W = $clog2(TIMEOUT + 1);
   logic [W-1:0] cnt_q;
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) cnt_q <= '0;
      else if (clr_i) cnt_q <= '0;
      else if (en_i) cnt_q <= cnt_q + W'(1);
   end
   assign expired_o = en_i && (cnt_q == W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction-fetch and data accesses onto one RAM port,
// with registered outputs, round-robin on contention and a sticky timeout flag.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        nRST,
   input  logic        imem_req,
   input  logic [31:0] imem_addr,
   output logic [31:0] imem_load,
   output logic        i_ready,
   input  logic        dmem_ren,
   input  logic        dmem_wen,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_store,
   output logic [31:0] dmem_load,
   output logic        d_ready,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_store,
   output logic        ram_ren,
   output logic        ram_wen,
   input  logic [31:0] ram_load,
   input  logic        ram_ready,
   output logic        bus_err
);
   state_e      state_q, state_d;
   grant_e      last_q, last_d;
   logic [31:0] addr_q, addr_d, store_q, store_d, iload_q, iload_d, dload_q, dload_d;
   logic        wr_q, wr_d, ren_q, ren_d, wen_q, wen_d;
   logic        irdy_q, irdy_d, drdy_q, drdy_d, err_q, err_d;
   logic        dreq, pick_data, grant, expired, done, in_access;
   logic [31:0] rd_word;

   assign dreq      = dmem_ren | dmem_wen;
   assign pick_data = dreq & (~imem_req | (last_q == INSTR));
   assign grant     = (state_q == IDLE) & (dreq | imem_req);
   assign in_access = (state_q == IFETCH) | (state_q == DACCESS);
   assign done      = ram_ready | expired;
   // a write completes with zero load data, as does an aborted access
   assign rd_word   = ram_ready ? (wr_q ? 32'h0 : ram_load) : ABORT_LOAD;

   arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk       (clk),
      .nRST      (nRST),
      .clr_i     (grant),
      .en_i      (in_access),
      .expired_o (expired)
   );

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      addr_d  = addr_q;
      store_d = store_q;
      wr_d    = wr_q;
      ren_d   = 1'b0;
      wen_d   = 1'b0;
      iload_d = iload_q;
      dload_d = dload_q;
      irdy_d  = 1'b0;
      drdy_d  = 1'b0;
      err_d   = err_q;
      case (state_q)
         IDLE: if (grant) begin
            state_d = pick_data ? DACCESS : IFETCH;
            last_d  = pick_data ? DATA : INSTR;
            addr_d  = pick_data ? dmem_addr : imem_addr;
            store_d = dmem_store;
            wr_d    = pick_data & dmem_wen;
            ren_d   = ~(pick_data & dmem_wen);
            wen_d   = pick_data & dmem_wen;
         end
         IFETCH, DACCESS: begin
            ren_d = ~done & ~wr_q;
            wen_d = ~done & wr_q;
            if (done) begin
               state_d = DONE;
               err_d   = err_q | ~ram_ready;
               irdy_d  = (state_q == IFETCH);
               drdy_d  = (state_q == DACCESS);
               iload_d = (state_q == IFETCH) ? rd_word : iload_q;
               dload_d = (state_q == DACCESS) ? rd_word : dload_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         last_q  <= INSTR;
         addr_q  <= '0;
         store_q <= '0;
         wr_q    <= 1'b0;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         iload_q <= '0;
         dload_q <= '0;
         irdy_q  <= 1'b0;
         drdy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         store_q <= store_d;
         wr_q    <= wr_d;
         ren_q   <= ren_d;
         wen_q   <= wen_d;
         iload_q <= iload_d;
         dload_q <= dload_d;
         irdy_q  <= irdy_d;
         drdy_q  <= drdy_d;
         err_q   <= err_d;
      end
   end

   assign ram_addr  = addr_q & 32'hFFFF_FFFC;
   assign ram_store = store_q;
   assign ram_ren   = ren_q;
   assign ram_wen   = wen_q;
   assign imem_load = iload_q;
   assign dmem_load = dload_q;
   assign i_ready   = irdy_q;
   assign d_ready   = drdy_q;
   assign bus_err   = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench with a transaction-level arbiter/RAM model.
module tb_mem_arbiter;
   localparam int TO = 4;

   logic        clk, nRST;
   logic        imem_req, i_ready, dmem_ren, dmem_wen, d_ready;
   logic [31:0] imem_addr, imem_load, dmem_addr, dmem_store, dmem_load;
   logic [31:0] ram_addr, ram_store, ram_load;
   logic        ram_ren, ram_wen, ram_ready, bus_err;

   mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .nRST(nRST),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_load(imem_load), .i_ready(i_ready),
      .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr), .dmem_store(dmem_store),
      .dmem_load(dmem_load), .d_ready(d_ready),
      .ram_addr(ram_addr), .ram_store(ram_store), .ram_ren(ram_ren), .ram_wen(ram_wen),
      .ram_load(ram_load), .ram_ready(ram_ready), .bus_err(bus_err)
   );

   typedef struct packed {logic side; logic [31:0] data; logic err;} exp_t;
   typedef struct packed {logic [31:0] addr; logic wr; logic [31:0] store; logic [7:0] lat;} ram_t;

   exp_t        exp_q[$];
   ram_t        ram_q[$];
   logic [31:0] ram_mem[int];
   logic [31:0] ref_mem[int];
   bit          ref_last;
   bit          ref_err;
   int          total = 0;
   int          bad = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return {a[31:2], 2'b11} ^ 32'h3C3C_0F0F;
   endfunction

   function automatic int eff(input int lat);
      return lat > TO ? TO : lat;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(int'(a[31:2])) ? ref_mem[int'(a[31:2])] : dflt(a);
   endfunction

   task automatic preload(input logic [31:0] a, input logic [31:0] v);
      ram_mem[int'(a[31:2])] = v;
      ref_mem[int'(a[31:2])] = v;
   endtask

   // reference model: one completed transaction, in service order
   task automatic model_serve(input bit side, input logic [31:0] a, input bit wr,
                              input logic [31:0] st, input int lat);
      bit          ok;
      logic [31:0] data;
      ok = (lat <= TO);
      ram_q.push_back('{addr: {a[31:2], 2'b00}, wr: wr, store: st, lat: 8'(lat)});
      data = (wr || !ok) ? 32'h0 : ref_rd(a);
      if (wr && ok) ref_mem[int'(a[31:2])] = st;
      ref_err  = ref_err | !ok;
      ref_last = side;
      exp_q.push_back('{side: side, data: data, err: ref_err});
   endtask

   task automatic round(input bit f, input bit d, input logic [31:0] fa, input logic [31:0] da,
                        input logic [31:0] ds, input bit dr, input bit dw,
                        input int fl, input int dl, input bit chk_lat);
      bit dfirst, pf, pd;
      int n;
      dfirst = d && (!f || !ref_last);
      if (dfirst) begin
         model_serve(1'b1, da, dw, ds, dl);
         if (f) model_serve(1'b0, fa, 1'b0, 32'h0, fl);
      end else begin
         model_serve(1'b0, fa, 1'b0, 32'h0, fl);
         if (d) model_serve(1'b1, da, dw, ds, dl);
      end
      @(negedge clk);
      imem_req = f; imem_addr = fa;
      dmem_ren = d & dr; dmem_wen = d & dw; dmem_addr = da; dmem_store = ds;
      pf = f; pd = d; n = 0;
      while ((pf || pd) && n < 100) begin
         @(negedge clk);
         n++;
         if (pf && i_ready) begin
            pf = 0; imem_req = 0;
            if (chk_lat && !d) chk("fetch latency", n, eff(fl) + 1);
         end
         if (pd && d_ready) begin
            pd = 0; dmem_ren = 0; dmem_wen = 0;
            if (chk_lat && !f) chk("data latency", n, eff(dl) + 1);
         end
      end
      chk("round completes", {30'h0, pf, pd}, 32'h0);
      imem_req = 0; dmem_ren = 0; dmem_wen = 0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " ram_addr"}, ram_addr, 32'h0);
      chk({tag, " ram_store"}, ram_store, 32'h0);
      chk({tag, " ctrl"}, {27'h0, ram_ren, ram_wen, i_ready, d_ready, bus_err}, 32'h0);
      chk({tag, " imem_load"}, imem_load, 32'h0);
      chk({tag, " dmem_load"}, dmem_load, 32'h0);
   endtask

   // RAM model: checks strobes against the expected access and acks on the chosen cycle
   initial begin
      int   scnt;
      ram_t cur;
      scnt = 0;
      cur = '0;
      ram_ready = 0;
      ram_load = 0;
      forever begin
         @(negedge clk);
         ram_ready = 0;
         ram_load = $urandom;
         if (!nRST) scnt = 0;
         else if (ram_ren || ram_wen) begin
            if (scnt == 0) begin
               if (ram_q.size() == 0) begin
                  chk("ram access expected", ram_q.size(), 1);
                  cur = '{addr: 32'h0, wr: 1'b0, store: 32'h0, lat: 8'd200};
               end else begin
                  cur = ram_q.pop_front();
                  chk("ram_addr", ram_addr, cur.addr);
                  chk("ram_wen", {31'h0, ram_wen}, {31'h0, cur.wr});
                  chk("ram_ren", {31'h0, ram_ren}, {31'h0, !cur.wr});
                  if (cur.wr) chk("ram_store", ram_store, cur.store);
               end
            end
            scnt++;
            if (scnt == int'(cur.lat)) begin
               ram_ready = 1;
               if (cur.wr) ram_mem[int'(ram_addr[31:2])] = ram_store;
               else ram_load = ram_mem.exists(int'(ram_addr[31:2])) ?
                               ram_mem[int'(ram_addr[31:2])] : dflt(ram_addr);
            end
         end else begin
            if (scnt != 0) chk("strobe length", scnt, eff(int'(cur.lat)));
            scnt = 0;
            ram_ready = ($urandom_range(0, 3) == 0);
         end
      end
   end

   // monitor: pops one expectation per ready pulse
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (nRST && (i_ready || d_ready)) begin
            chk("single ready", {31'h0, i_ready & d_ready}, 32'h0);
            if (exp_q.size() == 0) chk("ready expected", exp_q.size(), 1);
            else begin
               e = exp_q.pop_front();
               chk("ready side", {31'h0, d_ready}, {31'h0, e.side});
               chk(e.side ? "dmem_load" : "imem_load", e.side ? dmem_load : imem_load, e.data);
               chk("bus_err", {31'h0, bus_err}, {31'h0, e.err});
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      nRST = 0; imem_req = 0; imem_addr = 0; dmem_ren = 0; dmem_wen = 0;
      dmem_addr = 0; dmem_store = 0; ref_last = 0; ref_err = 0;
      #3 check_zero("reset");
      @(negedge clk);
      #2 nRST = 1;
      // contention from reset: data first, then fetch
      round(1, 1, 32'h20, 32'h30, 32'h0, 1, 0, 2, 1, 0);
      round(0, 1, 32'h0, 32'h44, 32'h0, 1, 0, 0, 2, 1);
      round(1, 1, 32'h24, 32'h48, 32'h0, 1, 0, 1, 3, 0);
      preload(32'h10, 32'h0051_3023);
      round(1, 0, 32'h10, 32'h0, 32'h0, 0, 0, 3, 0, 1);
      round(0, 1, 32'h0, 32'h106, 32'hCAFE_F00D, 0, 1, 0, 1, 1);
      round(0, 1, 32'h0, 32'h208, 32'h1234_5678, 1, 1, 0, 2, 1);
      round(0, 1, 32'h0, 32'h107, 32'h0, 1, 0, 0, 1, 1);
      round(0, 1, 32'h0, 32'h20B, 32'h0, 1, 0, 0, 4, 1);
      round(1, 0, 32'h10, 32'h0, 32'h0, 0, 0, 99, 0, 1);
      for (int i = 0; i < 40; i++) begin
         bit f, d;
         logic [1:0] op;
         f = 1'($urandom_range(0, 1));
         d = f ? 1'($urandom_range(0, 1)) : 1'b1;
         op = 2'($urandom_range(1, 3));
         round(f, d, 32'($urandom_range(0, 63)), 32'($urandom_range(0, 63)), $urandom,
               op[0], op[1], $urandom_range(1, 5), $urandom_range(1, 5), 1);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      // reset in the middle of a data access
      @(negedge clk);
      ram_q.push_back('{addr: 32'h300, wr: 1'b0, store: 32'h0, lat: 8'd99});
      dmem_ren = 1; dmem_addr = 32'h300;
      @(negedge clk);
      @(negedge clk);
      chk("ram_ren mid-access", {31'h0, ram_ren}, 32'h1);
      #2 nRST = 0;
      #1 check_zero("mid reset");
      dmem_ren = 0;
      exp_q.delete(); ram_q.delete();
      ref_err = 0; ref_last = 0;
      @(negedge clk);
      #2 nRST = 1;
      round(1, 1, 32'h40, 32'h48, 32'h0, 1, 0, 1, 2, 0);
      round(1, 0, 32'h4C, 32'h0, 32'h0, 0, 0, 2, 0, 1);
      repeat (3) @(negedge clk);
      chk("scoreboard drained", exp_q.size(), 0);
      chk("ram queue drained", ram_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
